// File: rtl/soc_fpga_ram_arb.sv
// Round-robin arbiter/sequencer for two requesters sharing one single-port RAM.
// Partial byte-enable writes become a read-modify-write over two cycles.
module soc_fpga_ram_arb #(
  parameter int DATAWIDTH = 32,
  parameter int ADDRWIDTH = 14,
  parameter int BEWIDTH   = DATAWIDTH / 8
) (
  input  logic                 PortAClk,
  input  logic                 PortARst,
  input  logic                 Req0Vld,
  output logic                 Req0Rdy,
  input  logic                 Req0Wr,
  input  logic [ADDRWIDTH-1:0] Req0Addr,
  input  logic [DATAWIDTH-1:0] Req0WData,
  input  logic [BEWIDTH-1:0]   Req0Be,
  output logic                 Rsp0Vld,
  output logic [DATAWIDTH-1:0] Rsp0RData,
  input  logic                 Req1Vld,
  output logic                 Req1Rdy,
  input  logic                 Req1Wr,
  input  logic [ADDRWIDTH-1:0] Req1Addr,
  input  logic [DATAWIDTH-1:0] Req1WData,
  input  logic [BEWIDTH-1:0]   Req1Be,
  output logic                 Rsp1Vld,
  output logic [DATAWIDTH-1:0] Rsp1RData,
  output logic [ADDRWIDTH-1:0] RamAddr,
  output logic [DATAWIDTH-1:0] RamDin,
  output logic                 RamWe,
  input  logic [DATAWIDTH-1:0] RamDout
);

  typedef enum logic {ACCEPT, MERGE} state_t;

  state_t state, stateNext;
  logic   LastGnt;
  logic   RspPend, RspOwner, RspIsRd;

  logic                 gnt0, gnt1, xfer;
  logic                 selWr;
  logic [ADDRWIDTH-1:0] selAddr;
  logic [DATAWIDTH-1:0] selWData;
  logic [BEWIDTH-1:0]   selBe;

  logic                 rmwLoad;
  logic                 complete, completeOwner, completeIsRd;
  logic [ADDRWIDTH-1:0] rmwAddr_p1;
  logic [DATAWIDTH-1:0] rmwWData_p1;
  logic [BEWIDTH-1:0]   rmwBe_p1;
  logic                 rmwOwner_p1;

  function automatic logic [DATAWIDTH-1:0] byteMerge(
    input logic [DATAWIDTH-1:0] oldWord,
    input logic [DATAWIDTH-1:0] newWord,
    input logic [BEWIDTH-1:0]   be
  );
    logic [DATAWIDTH-1:0] merged;
    for (int i = 0; i < BEWIDTH; i++) begin
      merged[8*i +: 8] = be[i] ? newWord[8*i +: 8] : oldWord[8*i +: 8];
    end
    return merged;
  endfunction

  // Grant: sole requester wins; on contention the one not granted last time wins.
  assign gnt0 = !PortARst && (state == ACCEPT) && Req0Vld && (!Req1Vld || LastGnt);
  assign gnt1 = !PortARst && (state == ACCEPT) && Req1Vld && (!Req0Vld || !LastGnt);
  assign xfer = gnt0 || gnt1;

  assign Req0Rdy = gnt0;
  assign Req1Rdy = gnt1;

  assign selWr    = gnt1 ? Req1Wr    : Req0Wr;
  assign selAddr  = gnt1 ? Req1Addr  : Req0Addr;
  assign selWData = gnt1 ? Req1WData : Req0WData;
  assign selBe    = gnt1 ? Req1Be    : Req0Be;

  always_comb begin
    stateNext     = state;
    RamAddr       = '0;
    RamDin        = '0;
    RamWe         = 1'b0;
    rmwLoad       = 1'b0;
    complete      = 1'b0;
    completeOwner = 1'b0;
    completeIsRd  = 1'b0;
    if (!PortARst) begin
      if (state == ACCEPT) begin
        if (xfer) begin
          complete      = 1'b1;
          completeOwner = gnt1;
          completeIsRd  = !selWr;
          if (!selWr) begin
            RamAddr = selAddr;
          end else if (&selBe) begin
            RamAddr = selAddr;
            RamDin  = selWData;
            RamWe   = 1'b1;
          end else if (selBe != '0) begin
            // Fetch the old word now; the write happens once it is on RamDout.
            RamAddr   = selAddr;
            rmwLoad   = 1'b1;
            complete  = 1'b0;
            stateNext = MERGE;
          end
        end
      end else begin
        RamAddr       = rmwAddr_p1;
        RamDin        = byteMerge(RamDout, rmwWData_p1, rmwBe_p1);
        RamWe         = 1'b1;
        complete      = 1'b1;
        completeOwner = rmwOwner_p1;
        stateNext     = ACCEPT;
      end
    end
  end

  always_ff @(posedge PortAClk) begin
    if (PortARst) begin
      state   <= ACCEPT;
      LastGnt <= 1'b1;
      RspPend <= 1'b0;
    end else begin
      state   <= stateNext;
      RspPend <= complete;
      if (xfer) LastGnt <= gnt1;
    end
  end

  // Stage p0 -> p1: capture the partial write for the merge cycle.
  always_ff @(posedge PortAClk) begin
    if (rmwLoad) begin
      rmwAddr_p1  <= selAddr;
      rmwWData_p1 <= selWData;
      rmwBe_p1    <= selBe;
      rmwOwner_p1 <= gnt1;
    end
    if (complete) begin
      RspOwner <= completeOwner;
      RspIsRd  <= completeIsRd;
    end
  end

  // Response stage: read data is the RAM's registered output of the previous cycle.
  assign Rsp0Vld   = !PortARst && RspPend && !RspOwner;
  assign Rsp1Vld   = !PortARst && RspPend && RspOwner;
  assign Rsp0RData = (Rsp0Vld && RspIsRd) ? RamDout : '0;
  assign Rsp1RData = (Rsp1Vld && RspIsRd) ? RamDout : '0;

endmodule

// File: tb/tb_soc_fpga_ram_arb.sv
// Scoreboard bench for soc_fpga_ram_arb with a behavioural single-port RAM.
module tb_soc_fpga_ram_arb;
  localparam int DW = 32;
  localparam int AW = 14;
  localparam int BW = DW / 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic          vld[2];
  logic          rdy[2];
  logic          wrS[2];
  logic [AW-1:0] addrS[2];
  logic [DW-1:0] wdS[2];
  logic [BW-1:0] beS[2];
  logic          rspVld[2];
  logic [DW-1:0] rspData[2];
  logic [AW-1:0] RamAddr;
  logic [DW-1:0] RamDin;
  logic          RamWe;
  logic [DW-1:0] ramDout;
  logic [DW-1:0] mem [0:(1<<AW)-1];

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;

  typedef struct {
    logic [DW-1:0] data;
    int            due;
  } exp_t;
  exp_t q0[$];
  exp_t q1[$];
  int   gntLog[$];
  logic gntLogOn = 1'b0;

  soc_fpga_ram_arb #(.DATAWIDTH(DW), .ADDRWIDTH(AW)) dut (
    .PortAClk(clk), .PortARst(rst),
    .Req0Vld(vld[0]), .Req0Rdy(rdy[0]), .Req0Wr(wrS[0]), .Req0Addr(addrS[0]),
    .Req0WData(wdS[0]), .Req0Be(beS[0]), .Rsp0Vld(rspVld[0]), .Rsp0RData(rspData[0]),
    .Req1Vld(vld[1]), .Req1Rdy(rdy[1]), .Req1Wr(wrS[1]), .Req1Addr(addrS[1]),
    .Req1WData(wdS[1]), .Req1Be(beS[1]), .Rsp1Vld(rspVld[1]), .Rsp1RData(rspData[1]),
    .RamAddr(RamAddr), .RamDin(RamDin), .RamWe(RamWe), .RamDout(ramDout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // RAM: registered read, output holds while writing.
  always @(posedge clk) begin
    if (RamWe) mem[RamAddr] <= RamDin;
    else       ramDout <= mem[RamAddr];
  end

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %b, expected %b (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int r, input logic [DW-1:0] d, input int due);
    exp_t e;
    e.data = d;
    e.due  = due;
    if (r == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  task automatic monitor(input int r);
    exp_t e;
    if (rspVld[r]) begin
      if ((r == 0 && q0.size() == 0) || (r == 1 && q1.size() == 0)) begin
        compared++;
        mismatched++;
        $display("FAIL rsp%0d_unexpected: got pulse with data 0x%08h, expected none (cycle %0d)",
                 r, rspData[r], cyc);
      end else begin
        if (r == 0) e = q0.pop_front();
        else        e = q1.pop_front();
        chk32($sformatf("rsp%0d_data", r), rspData[r], e.data);
        chk32($sformatf("rsp%0d_cycle", r), 32'(cyc), 32'(e.due));
      end
    end
  endtask

  always @(negedge clk) begin
    monitor(0);
    monitor(1);
    if (gntLogOn) begin
      if (vld[0] && rdy[0]) gntLog.push_back(0);
      if (vld[1] && rdy[1]) gntLog.push_back(1);
    end
  end

  task automatic drive(input int r, input logic w, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input logic [BW-1:0] b);
    wrS[r] = w; addrS[r] = a; wdS[r] = d; beS[r] = b; vld[r] = 1'b1;
  endtask

  // Hold a request until accepted, queue its expected response, then release.
  task automatic issue(input int r, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input logic [BW-1:0] b, input logic [DW-1:0] exp, input int lat,
                       output int waited);
    waited = 0;
    drive(r, w, a, d, b);
    do begin
      @(negedge clk);
      waited++;
    end while (!rdy[r] && waited < 50);
    if (!rdy[r]) begin
      compared++;
      mismatched++;
      $display("FAIL req%0d_accept_timeout: got no Rdy in %0d cycles, expected Rdy", r, waited);
    end else begin
      push(r, exp, cyc + lat);
    end
    @(posedge clk);
    #1 vld[r] = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got simulation still running, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0, w1;
    int expG[4];
    expG[0] = 0; expG[1] = 1; expG[2] = 0; expG[3] = 1;
    for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
    mem[14'h10] = 32'hDEADBEEF;
    mem[14'h20] = 32'h11223344;
    mem[14'h50] = 32'h55667788;
    mem[14'h60] = 32'hCAFEF00D;
    for (int r = 0; r < 2; r++) begin
      vld[r] = 1'b0; wrS[r] = 1'b0; addrS[r] = '0; wdS[r] = '0; beS[r] = '0;
    end

    // Reset: requests offered but nothing may be granted or written.
    repeat (2) @(posedge clk);
    #1 drive(0, 1'b1, 14'h10, 32'hFFFFFFFF, 4'hF);
    drive(1, 1'b0, 14'h10, '0, '0);
    @(negedge clk);
    chk1("rst_rdy0", rdy[0], 1'b0);
    chk1("rst_rdy1", rdy[1], 1'b0);
    chk1("rst_we", RamWe, 1'b0);
    chk32("rst_addr", 32'(RamAddr), 32'h0);
    @(posedge clk);
    #1 rst = 1'b0;
    vld[0] = 1'b0; vld[1] = 1'b0;

    // Single read by requester 0, accepted immediately.
    issue(0, 1'b0, 14'h10, '0, '0, 32'hDEADBEEF, 1, w0);
    chk32("rd0_wait", 32'(w0), 32'd1);

    // Be==0 write from requester 1: response only, no RAM write.
    drive(1, 1'b1, 14'h40, 32'h99999999, 4'b0000);
    @(negedge clk);
    chk1("be0_rdy", rdy[1], 1'b1);
    chk1("be0_we", RamWe, 1'b0);
    push(1, '0, cyc + 1);
    @(posedge clk);
    #1 vld[1] = 1'b0;
    @(negedge clk);
    chk1("be0_we_next", RamWe, 1'b0);
    chk32("idle_din", RamDin, 32'h0);
    @(posedge clk);
    #1;

    // Contention: both hold reads; grants must alternate starting with 0.
    gntLogOn = 1'b1;
    fork
      begin
        issue(0, 1'b0, 14'h10, '0, '0, 32'hDEADBEEF, 1, w0);
        issue(0, 1'b0, 14'h20, '0, '0, 32'h11223344, 1, w0);
      end
      begin
        issue(1, 1'b0, 14'h50, '0, '0, 32'h55667788, 1, w1);
        issue(1, 1'b0, 14'h60, '0, '0, 32'hCAFEF00D, 1, w1);
      end
    join
    gntLogOn = 1'b0;
    chk32("gnt_count", 32'(gntLog.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < gntLog.size()) chk32($sformatf("gnt_order%0d", i), 32'(gntLog[i]), 32'(expG[i]));
    end

    // Partial write by requester 1 with requester 0 waiting through the merge.
    drive(1, 1'b1, 14'h20, 32'hAABBCCDD, 4'b0101);
    @(negedge clk);
    chk1("pw_rdy", rdy[1], 1'b1);
    chk1("pw_read_we", RamWe, 1'b0);
    chk32("pw_read_addr", 32'(RamAddr), 32'h20);
    push(1, '0, cyc + 2);
    @(posedge clk);
    #1 vld[1] = 1'b0;
    drive(0, 1'b0, 14'h20, '0, '0);
    @(negedge clk);
    chk1("merge_rdy0", rdy[0], 1'b0);
    chk1("merge_rdy1", rdy[1], 1'b0);
    chk1("merge_we", RamWe, 1'b1);
    chk32("merge_addr", 32'(RamAddr), 32'h20);
    chk32("merge_din", RamDin, 32'h11BB33DD);
    @(negedge clk);
    chk1("post_merge_rdy0", rdy[0], 1'b1);
    push(0, 32'h11BB33DD, cyc + 1);
    @(posedge clk);
    #1 vld[0] = 1'b0;

    // Full write then an immediate read of the same word.
    drive(0, 1'b1, 14'h30, 32'h12345678, 4'hF);
    @(negedge clk);
    chk1("fw_rdy", rdy[0], 1'b1);
    chk1("fw_we", RamWe, 1'b1);
    chk32("fw_din", RamDin, 32'h12345678);
    push(0, '0, cyc + 1);
    @(posedge clk);
    #1 drive(0, 1'b0, 14'h30, '0, '0);
    @(negedge clk);
    chk1("fw_rd_rdy", rdy[0], 1'b1);
    push(0, 32'h12345678, cyc + 1);
    @(posedge clk);
    #1 vld[0] = 1'b0;

    // Reset during the merge cycle drops the write and its response.
    drive(0, 1'b1, 14'h50, 32'hFFFFFFFF, 4'b0011);
    @(negedge clk);
    chk1("rmw_rst_rdy", rdy[0], 1'b1);
    @(posedge clk);
    #1 rst = 1'b1;
    drive(0, 1'b0, 14'h50, '0, '0);
    drive(1, 1'b0, 14'h10, '0, '0);
    @(negedge clk);
    chk1("rmw_rst_we", RamWe, 1'b0);
    chk32("rmw_rst_addr", 32'(RamAddr), 32'h0);
    chk32("rmw_rst_din", RamDin, 32'h0);
    chk1("rmw_rst_rdy0", rdy[0], 1'b0);
    chk1("rmw_rst_rdy1", rdy[1], 1'b0);
    chk1("rmw_rst_rsp0", rspVld[0], 1'b0);
    chk32("rmw_rst_rdata0", rspData[0], 32'h0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk1("after_rst_rdy0", rdy[0], 1'b1);
    chk1("after_rst_rdy1", rdy[1], 1'b0);
    push(0, 32'h55667788, cyc + 1);
    @(posedge clk);
    #1 vld[0] = 1'b0;
    @(negedge clk);
    chk1("after_rst_rdy1b", rdy[1], 1'b1);
    push(1, 32'hDEADBEEF, cyc + 1);
    @(posedge clk);
    #1 vld[1] = 1'b0;

    repeat (4) @(negedge clk);
    chk32("mem50_kept", mem[14'h50], 32'h55667788);
    chk32("q0_drained", 32'(q0.size()), 32'd0);
    chk32("q1_drained", 32'(q1.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/soc_fpga_ram_arb.md
Name: soc_fpga_ram_arb

Overview:
- Two-requester round-robin arbiter and sequencer for one single-port FPGA RAM (1-cycle registered read; read data updates only when write enable is low).
- Adds byte-enable writes: a partial write becomes an internal read-modify-write (RMW), because the RAM has no byte enables.
- Sits between the instruction-fetch and data ports and the RAM instance in the FPGA SoC memory subsystem.

Parameters:
DATAWIDTH, 32, RAM word width; must be a multiple of 8
ADDRWIDTH, 14, RAM word-address width
BEWIDTH, DATAWIDTH/8, byte-enable width (derived; do not override)

Ports:
PortAClk  in  1  clock; all state changes on its rising edge
PortARst  in  1  synchronous, active-high reset
Req0Vld  in  1  requester 0 request valid
Req0Rdy  out  1  requester 0 request accepted this cycle (combinational)
Req0Wr  in  1  1 = write, 0 = read
Req0Addr  in  ADDRWIDTH  word address
Req0WData  in  DATAWIDTH  write data
Req0Be  in  BEWIDTH  byte enables (writes only)
Rsp0Vld  out  1  one-cycle response pulse for requester 0
Rsp0RData  out  DATAWIDTH  read data; 0 for write responses
Req1Vld, Req1Rdy, Req1Wr, Req1Addr, Req1WData, Req1Be, Rsp1Vld, Rsp1RData: same as requester 0
RamAddr  out  ADDRWIDTH  RAM address
RamDin  out  DATAWIDTH  RAM write data
RamWe  out  1  RAM write enable
RamDout  in  DATAWIDTH  RAM registered read data

Behaviour:
- State machine: states ACCEPT and MERGE; reset state is ACCEPT.
- Handshake: a request transfers when ReqNVld && ReqNRdy. Rdy is asserted only in state ACCEPT, only for the grant winner, and is 0 while PortARst=1. Rdy may depend on Vld. Requesters hold Vld, Wr, Addr, WData and Be stable until Rdy.
- Arbitration: a register LastGnt resets to 1, so requester 0 wins first. If only one requester is valid, it wins. If both are valid, the winner is !LastGnt. LastGnt updates only on a transfer.
- Read accepted in cycle T: RamAddr=Addr and RamWe=0 in T. In T+1, RspNVld=1 and RspNRData=RamDout.
- Full write (Be all ones) accepted in T: RamAddr=Addr, RamDin=WData, RamWe=1 in T. RspNVld=1 in T+1 with RData=0.
- Be==0 write accepted in T: no RAM access, RamWe stays 0. RspNVld=1 in T+1 with RData=0.
- Partial write accepted in T:
  - In T: issue a RAM read (RamWe=0); latch addr, wdata, be and owner; next state MERGE.
  - In MERGE (T+1): RamWe=1, RamAddr=latched addr. For each byte i, RamDin byte i = be[i] ? wdata byte i : RamDout byte i. Both Rdy outputs are 0.
  - Return to ACCEPT; RspNVld=1 in T+2.
- Response register: RspPend, RspOwner and RspIsRd are set at the end of the completing cycle. Responses have no backpressure, and exactly one response is produced per accepted request, in acceptance order per requester.
- Back-to-back: a new request may be accepted in the same cycle a response pulses. Sustained throughput is 1 request/cycle for reads and full writes, and 1 per 2 cycles for partial writes.
- Coherence: a read accepted the cycle after any write completes returns the new data; no forwarding is needed.
- Idle: when no transfer and not in MERGE, RamWe=0, RamAddr=0 and RamDin=0.
- Reset (any cycle, including mid-RMW):
  - State goes to ACCEPT, LastGnt=1, RspPend=0.
  - While PortARst=1: RamWe=0, RamAddr=0, RamDin=0, both Rdy=0, both RspVld=0, both RspRData=0.
  - An in-flight RMW is dropped: no RAM write and no response.

Test Plan:
- Reset, then Req0 reads 0x10 (preloaded 0xDEADBEEF) -> Req0Rdy in cycle 0, Rsp0Vld=1 with Rsp0RData=0xDEADBEEF in cycle 1, Rsp1Vld=0 throughout.
- Req0 and Req1 both hold valid reads for 4 cycles -> grants go 0,1,0,1, one response per cycle to the matching requester, and LastGnt alternates.
- Req1 writes 0x20 with data 0xAABBCCDD and Be=0101 over old value 0x11223344 -> no Rdy in the MERGE cycle, RamWe=1 with RamDin=0x11BB33DD, Rsp1Vld 2 cycles after accept; a following read of 0x20 returns 0x11BB33DD.
- Full write 0x30=0x12345678 in cycle T followed by a read of 0x30 in T+1 -> the read response in T+2 is 0x12345678.
- Assert PortARst during the MERGE cycle of a partial write -> RamWe=0, no Rsp pulse, memory unchanged, and requester 0 wins first after reset.
- Write with Be=0000 -> RamWe never asserted, Rsp pulses after 1 cycle with RData=0.
